// File: rtl/processador_multiciclo_param_if.sv
// Bus-side signal bundle of processador_multiciclo_param: instruction/data input,
// start handshake and the debug observation outputs.
interface processador_multiciclo_param_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] DIN;
    logic              Run;
    logic              Done;
    logic [DATA_W-1:0] BusWires;
    logic [DATA_W-1:0] Rx_data;
    logic [DATA_W-1:0] Ry_data;

    modport master (
        output DIN,
        output Run,
        input  Done,
        input  BusWires,
        input  Rx_data,
        input  Ry_data
    );

    modport slave (
        input  DIN,
        input  Run,
        output Done,
        output BusWires,
        output Rx_data,
        output Ry_data
    );
endinterface

// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor: register file, A, G and ALU on one shared bus.
// Optional macro PROC_MULTI_MVNZ_EN turns opcode 111 into mvnz; otherwise it is a NOP.
module processador_multiciclo_param #(
    parameter int DATA_W    = 16,
    parameter int REG_SEL_W = 3
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    processador_multiciclo_param_if.slave bus_if
);
    localparam int NREG = 1 << REG_SEL_W;
    localparam int IR_W = 3 + 2 * REG_SEL_W;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_EXT  = 3'b111;

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_REG, SRC_G, SRC_DIN} bus_src_t;

    step_t                step_reg, step_next;
    logic [IR_W-1:0]      ir_reg;
    logic [DATA_W-1:0]    a_reg;
    logic [DATA_W-1:0]    g_reg;
    logic [DATA_W-1:0]    regs_reg [NREG];

    logic [2:0]           opcode;
    logic [REG_SEL_W-1:0] x_sel;
    logic [REG_SEL_W-1:0] y_sel;

    bus_src_t             bus_src;
    logic [REG_SEL_W-1:0] bus_reg_sel;
    logic [DATA_W-1:0]    bus_value;
    logic [DATA_W-1:0]    alu_result;
    logic                 ir_load;
    logic                 a_load;
    logic                 g_load;
    logic                 r_write;
    logic                 done;
    logic [NREG-1:0]      write_sel;

    assign opcode = ir_reg[IR_W-1 -: 3];
    assign x_sel  = ir_reg[2*REG_SEL_W-1 -: REG_SEL_W];
    assign y_sel  = ir_reg[REG_SEL_W-1:0];

    // Step register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_reg <= T0;
        end else begin
            step_reg <= step_next;
        end
    end

    // Control: next step, bus source and load enables
    always_comb begin
        step_next   = step_reg;
        bus_src     = SRC_NONE;
        bus_reg_sel = y_sel;
        ir_load     = 1'b0;
        a_load      = 1'b0;
        g_load      = 1'b0;
        r_write     = 1'b0;
        done        = 1'b0;
        case (step_reg)
            T0: begin
                if (bus_if.Run) begin
                    ir_load   = 1'b1;
                    step_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus_src   = SRC_REG;
                        r_write   = 1'b1;
                        done      = 1'b1;
                        step_next = T0;
                    end
                    OP_MVI: begin
                        bus_src   = SRC_DIN;
                        r_write   = 1'b1;
                        done      = 1'b1;
                        step_next = T0;
                    end
                    OP_EXT: begin
`ifdef PROC_MULTI_MVNZ_EN
                        if (g_reg != '0) begin
                            bus_src = SRC_REG;
                            r_write = 1'b1;
                        end
`endif
                        done      = 1'b1;
                        step_next = T0;
                    end
                    default: begin
                        // ALU ops latch the first operand Rx into A
                        bus_src     = SRC_REG;
                        bus_reg_sel = x_sel;
                        a_load      = 1'b1;
                        step_next   = T2;
                    end
                endcase
            end
            T2: begin
                bus_src   = SRC_REG;
                g_load    = 1'b1;
                step_next = T3;
            end
            T3: begin
                bus_src   = SRC_G;
                r_write   = 1'b1;
                done      = 1'b1;
                step_next = T0;
            end
            default: begin
                step_next = T0;
            end
        endcase
    end

    // Shared bus multiplexer; zero when nothing drives it
    always_comb begin
        bus_value = '0;
        case (bus_src)
            SRC_REG:  bus_value = regs_reg[bus_reg_sel];
            SRC_G:    bus_value = g_reg;
            SRC_DIN:  bus_value = bus_if.DIN;
            default:  bus_value = '0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_ADD:  alu_result = a_reg + bus_value;
            OP_SUB:  alu_result = a_reg - bus_value;
            OP_AND:  alu_result = a_reg & bus_value;
            OP_OR:   alu_result = a_reg | bus_value;
            OP_SLT:  alu_result = (a_reg < bus_value) ? DATA_W'(1) : '0;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ir_reg <= '0;
            a_reg  <= '0;
            g_reg  <= '0;
        end else begin
            if (ir_load) begin
                ir_reg <= bus_if.DIN[IR_W-1:0];
            end
            if (a_load) begin
                a_reg <= bus_value;
            end
            if (g_load) begin
                g_reg <= alu_result;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wsel
            assign write_sel[gi] = r_write && (x_sel == REG_SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (write_sel[i]) begin
                    regs_reg[i] <= bus_value;
                end
            end
        end
    end

    assign bus_if.Done     = done;
    assign bus_if.BusWires = bus_value;
    assign bus_if.Rx_data  = regs_reg[x_sel];
    assign bus_if.Ry_data  = regs_reg[y_sel];

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Directed bench for processador_multiciclo_param (DATA_W=16, REG_SEL_W=3);
// builds with or without PROC_MULTI_MVNZ_EN.
module tb_processador_multiciclo_param;
    logic Clock;
    logic Resetn;
    int   checks = 0;
    int   errors = 0;

    processador_multiciclo_param_if #(.DATA_W(16)) pbus ();

    processador_multiciclo_param #(
        .DATA_W    (16),
        .REG_SEL_W (3)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus_if (pbus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    // Fetch one instruction and walk its steps, checking Done on every step
    task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                        input logic [15:0] imm, input int nsteps, input logic run_during);
        pbus.DIN = {7'd0, op, x, y};
        pbus.Run = 1'b1;
        #1;
        chk("t0_done", {15'd0, pbus.Done}, 16'd0);
        chk("t0_bus", pbus.BusWires, 16'd0);
        tick();
        pbus.DIN = imm;
        pbus.Run = run_during;
        for (int s = 1; s <= nsteps; s++) begin
            #1;
            chk("step_done", {15'd0, pbus.Done}, (s == nsteps) ? 16'd1 : 16'd0);
            if (op == 3'b001 && s == 1) chk("mvi_bus", pbus.BusWires, imm);
            tick();
        end
        pbus.Run = 1'b0;
        #1;
    endtask

    initial begin
        Resetn   = 1'b0;
        pbus.DIN = '0;
        pbus.Run = 1'b0;
        tick();
        chk("rst_done", {15'd0, pbus.Done}, 16'd0);
        chk("rst_bus", pbus.BusWires, 16'd0);
        chk("rst_rx", pbus.Rx_data, 16'd0);
        chk("rst_ry", pbus.Ry_data, 16'd0);
        Resetn = 1'b1;

        exec(3'b001, 3'd0, 3'd0, 16'h0005, 1, 1'b0);
        chk("mvi_r0", pbus.Rx_data, 16'h0005);
        exec(3'b001, 3'd1, 3'd0, 16'h0003, 1, 1'b0);
        chk("mvi_r1", pbus.Rx_data, 16'h0003);
        chk("mvi_r1_ry", pbus.Ry_data, 16'h0005);

        exec(3'b010, 3'd0, 3'd1, 16'h0000, 3, 1'b1);
        chk("add_r0", pbus.Rx_data, 16'h0008);
        chk("add_r0_ry", pbus.Ry_data, 16'h0003);
        exec(3'b011, 3'd1, 3'd0, 16'h0000, 3, 1'b0);
        chk("sub_wrap", pbus.Rx_data, 16'hFFFB);
        chk("sub_ry", pbus.Ry_data, 16'h0008);

        exec(3'b001, 3'd2, 3'd0, 16'hFFFF, 1, 1'b0);
        exec(3'b001, 3'd3, 3'd0, 16'h0001, 1, 1'b0);
        exec(3'b010, 3'd2, 3'd3, 16'h0000, 3, 1'b1);
        chk("add_wrap", pbus.Rx_data, 16'h0000);
        chk("add_wrap_ry", pbus.Ry_data, 16'h0001);
        exec(3'b001, 3'd4, 3'd0, 16'h00F0, 1, 1'b0);
        exec(3'b100, 3'd4, 3'd3, 16'h0000, 3, 1'b0);
        chk("and_r4", pbus.Rx_data, 16'h0000);
        exec(3'b110, 3'd3, 3'd2, 16'h0000, 3, 1'b1);
        chk("slt_false", pbus.Rx_data, 16'h0000);
        exec(3'b101, 3'd4, 3'd1, 16'h0000, 3, 1'b0);
        chk("or_r4", pbus.Rx_data, 16'hFFFB);
        exec(3'b110, 3'd2, 3'd1, 16'h0000, 3, 1'b0);
        chk("slt_true", pbus.Rx_data, 16'h0001);
        exec(3'b000, 3'd7, 3'd4, 16'h0000, 1, 1'b1);
        chk("mv_r7", pbus.Rx_data, 16'hFFFB);
        exec(3'b001, 3'd1, 3'd0, 16'h1234, 1, 1'b0);
        exec(3'b010, 3'd1, 3'd1, 16'h0000, 3, 1'b0);
        chk("add_self", pbus.Rx_data, 16'h2468);

        pbus.Run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("idle_done", {15'd0, pbus.Done}, 16'd0);
            chk("idle_bus", pbus.BusWires, 16'd0);
            chk("idle_rx", pbus.Rx_data, 16'h2468);
            tick();
            #1;
        end

        // G = 7 via add R5,R6 with R5=7, R6=0
        exec(3'b001, 3'd5, 3'd0, 16'h0007, 1, 1'b0);
        exec(3'b001, 3'd6, 3'd0, 16'h0000, 1, 1'b0);
        exec(3'b010, 3'd5, 3'd6, 16'h0000, 3, 1'b0);
        chk("g_seven", pbus.Rx_data, 16'h0007);
        exec(3'b001, 3'd5, 3'd0, 16'h0002, 1, 1'b0);
        exec(3'b001, 3'd6, 3'd0, 16'h0009, 1, 1'b0);
        exec(3'b111, 3'd5, 3'd6, 16'h0000, 1, 1'b0);
`ifdef PROC_MULTI_MVNZ_EN
        chk("op7_gnz", pbus.Rx_data, 16'h0009);
`else
        chk("op7_gnz", pbus.Rx_data, 16'h0002);
`endif
        chk("op7_ry", pbus.Ry_data, 16'h0009);
        exec(3'b011, 3'd5, 3'd5, 16'h0000, 3, 1'b0);
        chk("sub_self", pbus.Rx_data, 16'h0000);
        exec(3'b001, 3'd5, 3'd0, 16'h0002, 1, 1'b0);
        exec(3'b111, 3'd5, 3'd6, 16'h0000, 1, 1'b0);
        chk("op7_gz", pbus.Rx_data, 16'h0002);

        // Reset pulse in T2 of add R0,R1 (R0=8, R1=0x2468)
        pbus.DIN = {7'd0, 3'b010, 3'd0, 3'd1};
        pbus.Run = 1'b1;
        tick();
        pbus.Run = 1'b0;
        tick();
        #1;
        chk("t2_bus", pbus.BusWires, 16'h2468);
        Resetn = 1'b0;
        #1;
        chk("arst_done", {15'd0, pbus.Done}, 16'd0);
        chk("arst_bus", pbus.BusWires, 16'd0);
        chk("arst_rx", pbus.Rx_data, 16'd0);
        chk("arst_ry", pbus.Ry_data, 16'd0);
        tick();
        Resetn = 1'b1;
        tick();
        tick();
        #1;
        chk("post_rst_done", {15'd0, pbus.Done}, 16'd0);
        chk("post_rst_rx", pbus.Rx_data, 16'd0);
        chk("post_rst_bus", pbus.BusWires, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
